// File: rtl/instr_sequencer.sv
// Hardwired control sequencer for the single-bus CPU datapath.
// Walks one instruction through fetch (T0..T2), register-format ALU
// decode (T3) and execute/write-back (T4..T6). It drives every datapath
// strobe as a Moore output of the current step. The only exception is
// T3, which decodes the live IR contents.
module instr_sequencer #(
  parameter int NREG        = 16,
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Mem_ready,
  input  logic [31:0]     IR_data,
  output logic            PCout,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] reg_out,
  output logic [NREG-1:0] reg_in,
  output logic [OP_W-1:0] operation,
  output logic            busy,
  output logic            halted,
  output logic            err_illegal,
  output logic            err_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  // Register-format opcodes handled by this sequencer
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       op_q;
  logic [3:0]       ra_q, rc_q;
  logic             md_q;
  logic             err_ill_q, err_to_q;

  // IR fields, decoded live while in T3
  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       op_alu, op_md, idx_ok, legal;
  logic       mem_timeout;

  assign ir_op = IR_data[31:27];
  assign ir_ra = IR_data[26:23];
  assign ir_rb = IR_data[22:19];
  assign ir_rc = IR_data[18:15];

  // One-hot select of a GPR from a 4-bit register field
  function automatic logic [NREG-1:0] reg_sel(input logic [3:0] idx);
    logic [NREG-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) r[i] = (idx == 4'(i));
    return r;
  endfunction

  // A register field must name an existing GPR when NREG < 16
  function automatic logic reg_ok(input logic [3:0] idx);
    return int'(idx) < NREG;
  endfunction

  // Opcode class decode: plain single-result ALU ops vs. MUL/DIV (HI/LO pair)
  always_comb begin
    op_alu = 1'b0;
    op_md  = 1'b0;
    case (ir_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL: op_alu = 1'b1;
      OP_MUL, OP_DIV:          op_md  = 1'b1;
      default: ;
    endcase
  end

  // MUL/DIV write HI/LO and never use Ra, so Ra is range-checked only for ALU ops
  assign idx_ok      = reg_ok(ir_rb) && reg_ok(ir_rc) && (op_md || reg_ok(ir_ra));
  assign legal       = (op_alu || op_md) && idx_ok;
  assign mem_timeout = !Mem_ready && (wait_cnt == CNT_LAST);

  // State register, T1 wait counter, latched instruction fields and sticky errors
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      op_q      <= '0;
      ra_q      <= '0;
      rc_q      <= '0;
      md_q      <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      // Counts cycles spent in T1; zero whenever T1 is next entered
      wait_cnt <= (state == S_T1) ? wait_cnt + 1'b1 : '0;
      if (state == S_T3 && legal) begin
        op_q <= ir_op;
        ra_q <= ir_ra;
        rc_q <= ir_rc;
        md_q <= op_md;
      end
      if (state == S_T3 && !legal) err_ill_q <= 1'b1;
      if (state == S_T1 && mem_timeout) err_to_q <= 1'b1;
    end
  end

  // Next-state and step strobes; every output defaults low
  always_comb begin
    state_nx  = state;
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    ZHighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    reg_out   = '0;
    reg_in    = '0;
    operation = '0;
    busy      = 1'b1;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (Run) state_nx = S_T0;
      end
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        Zin      = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        // Read stays asserted for the whole wait; PC is loaded once only
        Zlowout = 1'b1;
        PCin    = (wait_cnt == '0);
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (Mem_ready)        state_nx = S_T2;
        else if (mem_timeout) state_nx = S_HALT;
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        if (legal) begin
          reg_out  = reg_sel(ir_rb);
          Yin      = 1'b1;
          state_nx = S_T4;
        end else begin
          state_nx = S_HALT;
        end
      end
      S_T4: begin
        reg_out   = reg_sel(rc_q);
        Zin       = 1'b1;
        operation = OP_W'(op_q);
        state_nx  = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (md_q) begin
          LOin     = 1'b1;
          state_nx = S_T6;
        end else begin
          reg_in   = reg_sel(ra_q);
          state_nx = Run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        state_nx = Run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: each step pushes the expected strobe
// set onto a scoreboard queue, clocks once, then pops and compares it
// against the DUT outputs.
module tb_instr_sequencer;

  localparam int NREG = 16;
  localparam int OP_W = 5;

  logic Clock = 1'b0, Reset = 1'b1, Run = 1'b0, Mem_ready = 1'b0;
  logic [31:0] IR_data = '0;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read;
  logic [NREG-1:0] reg_out, reg_in;
  logic [OP_W-1:0] operation;
  logic busy, halted, err_illegal, err_timeout;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin;
    logic yin, zin, hiin, loin, incpc, read;
    logic [NREG-1:0] rout, rin;
    logic [OP_W-1:0] op;
    logic busy, halted, eill, eto;
  } obs_t;

  obs_t obs;
  obs_t sb[$];
  int total = 0;
  int bad   = 0;

  assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, Zin, HIin, LOin, IncPC, Read, reg_out, reg_in, operation,
                busy, halted, err_illegal, err_timeout};

  instr_sequencer #(.NREG(NREG), .OP_W(OP_W), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_ready(Mem_ready),
    .IR_data(IR_data), .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .reg_out(reg_out), .reg_in(reg_in), .operation(operation), .busy(busy),
    .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 Clock = ~Clock;

  // Expected strobe sets for each step
  function automatic obs_t e_idle();
    obs_t e = '0;
    return e;
  endfunction
  function automatic obs_t e_t0();
    obs_t e = '0;
    e.busy = 1; e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin = 1;
    return e;
  endfunction
  function automatic obs_t e_t1(input logic first);
    obs_t e = '0;
    e.busy = 1; e.zlowout = 1; e.pcin = first; e.read = 1; e.mdrin = 1;
    return e;
  endfunction
  function automatic obs_t e_t2();
    obs_t e = '0;
    e.busy = 1; e.mdrout = 1; e.irin = 1;
    return e;
  endfunction
  function automatic obs_t e_t3(input int rb);
    obs_t e = '0;
    e.busy = 1; e.yin = 1; e.rout[rb] = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_t3_bad();
    obs_t e = '0;
    e.busy = 1;
    return e;
  endfunction
  function automatic obs_t e_t4(input int rc, input logic [4:0] op);
    obs_t e = '0;
    e.busy = 1; e.zin = 1; e.rout[rc] = 1'b1; e.op = op;
    return e;
  endfunction
  function automatic obs_t e_t5(input int ra, input logic md);
    obs_t e = '0;
    e.busy = 1; e.zlowout = 1;
    if (md) e.loin = 1; else e.rin[ra] = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_t6();
    obs_t e = '0;
    e.busy = 1; e.zhighout = 1; e.hiin = 1;
    return e;
  endfunction
  function automatic obs_t e_halt(input logic ill, input logic to);
    obs_t e = '0;
    e.halted = 1; e.eill = ill; e.eto = to;
    return e;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra, input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  // One clock: queue the expectation, advance, then pop and compare
  task automatic step(input obs_t e, input string tag);
    obs_t x;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    x = sb.pop_front();
    total++;
    assert (obs === x) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, x);
    end
    total++;
    assert (($onehot0({PCout, Zlowout, ZHighout, MDRout, |reg_out}) && $onehot0(reg_out)) === 1'b1) else begin
      bad++;
      $error("FAIL %s_bus got=%b/%h exp=onehot0", tag, {PCout, Zlowout, ZHighout, MDRout}, reg_out);
    end
  endtask

  initial begin
    // Reset state
    step(e_idle(), "reset0");
    step(e_idle(), "reset1");

    // 1: SHRA R4,R3,R7 with immediate memory
    Reset = 0; Run = 1; Mem_ready = 1;
    IR_data = 32'h521B8000;
    step(e_t0(), "shra_t0");
    step(e_t1(1), "shra_t1");
    step(e_t2(), "shra_t2");
    step(e_t3(3), "shra_t3");
    step(e_t4(7, 5'b01010), "shra_t4");
    step(e_t5(4, 0), "shra_t5");
    // 2: ADD R1,R2,R3 with Mem_ready late by 3 cycles
    IR_data = mk_ir(5'b00011, 1, 2, 3);
    Mem_ready = 0;
    step(e_t0(), "shra_next_t0");
    step(e_t1(1), "add_t1a");
    step(e_t1(0), "add_t1b");
    step(e_t1(0), "add_t1c");
    step(e_t1(0), "add_t1d");
    Mem_ready = 1;
    step(e_t2(), "add_t2");
    step(e_t3(2), "add_t3");
    step(e_t4(3, 5'b00011), "add_t4");
    step(e_t5(1, 0), "add_t5");

    // 3: MUL R5,R0 -> LO then HI, no GPR write; Run dropped at the end step
    IR_data = mk_ir(5'b01111, 2, 5, 0);
    step(e_t0(), "mul_t0");
    step(e_t1(1), "mul_t1");
    step(e_t2(), "mul_t2");
    step(e_t3(5), "mul_t3");
    step(e_t4(0, 5'b01111), "mul_t4");
    step(e_t5(0, 1), "mul_t5");
    Run = 0;
    step(e_t6(), "mul_t6");
    step(e_idle(), "mul_idle");
    step(e_idle(), "idle_hold");

    // 6: Reset in T4 aborts to IDLE; then Run=0 in T5 ends in IDLE
    Run = 1;
    IR_data = mk_ir(5'b00100, 6, 9, 15);
    step(e_t0(), "rst_t0");
    step(e_t1(1), "rst_t1");
    step(e_t2(), "rst_t2");
    step(e_t3(9), "rst_t3");
    step(e_t4(15, 5'b00100), "rst_t4");
    Reset = 1;
    step(e_idle(), "rst_abort");
    Reset = 0;
    step(e_t0(), "sub_t0");
    step(e_t1(1), "sub_t1");
    step(e_t2(), "sub_t2");
    step(e_t3(9), "sub_t3");
    step(e_t4(15, 5'b00100), "sub_t4");
    Run = 0;
    step(e_t5(6, 0), "sub_t5");
    step(e_idle(), "sub_idle");

    // 4: illegal opcode halts; Run toggling cannot leave HALT
    Run = 1;
    IR_data = mk_ir(5'b11111, 1, 2, 3);
    step(e_t0(), "ill_t0");
    step(e_t1(1), "ill_t1");
    step(e_t2(), "ill_t2");
    step(e_t3_bad(), "ill_t3");
    step(e_halt(1, 0), "ill_halt");
    Run = 0;
    step(e_halt(1, 0), "ill_run0");
    Run = 1;
    step(e_halt(1, 0), "ill_run1");
    Reset = 1;
    step(e_idle(), "ill_clear");

    // Mem_ready arriving in the last allowed T1 cycle still completes the fetch
    Reset = 0; Mem_ready = 0;
    IR_data = mk_ir(5'b01011, 3, 4, 5);
    step(e_t0(), "edge_t0");
    step(e_t1(1), "edge_t1_1");
    for (int i = 2; i <= 15; i++) step(e_t1(0), $sformatf("edge_t1_%0d", i));
    Mem_ready = 1;
    step(e_t2(), "edge_t2");
    step(e_t3(4), "edge_t3");
    step(e_t4(5, 5'b01011), "edge_t4");
    step(e_t5(3, 0), "edge_t5");

    // 5: no Mem_ready -> timeout after 15 T1 cycles
    Mem_ready = 0;
    step(e_t0(), "to_t0");
    step(e_t1(1), "to_t1_1");
    for (int i = 2; i <= 15; i++) step(e_t1(0), $sformatf("to_t1_%0d", i));
    step(e_halt(0, 1), "to_halt");
    Mem_ready = 1;
    step(e_halt(0, 1), "to_hold");
    Reset = 1;
    step(e_idle(), "to_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
